// File: rtl/rst_req_ctrl_pkg.sv
// Shared types and helpers for the reset-request controller.
package rst_req_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STRETCH = 2'd1,
        HOLD    = 2'd2
    } rst_req_state_e;

    // The software cause bit sits directly above the hardware source bits.
    localparam int unsigned SwCauseOffset = 0;

    function automatic int unsigned sw_cause_idx(input int unsigned num_src);
        return num_src + SwCauseOffset;
    endfunction

endpackage

// File: rtl/rst_req_ctrl_sync.sv
// Multi-flop level synchronizer, same interface as the common_cells sync cell.
module rst_req_ctrl_sync #(
    parameter int unsigned STAGES     = 2,
    parameter bit          ResetValue = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic serial_i,
    output logic serial_o
);

    logic [STAGES-1:0] reg_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            reg_q <= {STAGES{ResetValue}};
        end else begin
            reg_q <= {reg_q[STAGES-2:0], serial_i};
        end
    end

    assign serial_o = reg_q[STAGES-1];

endmodule

// File: rtl/rst_req_ctrl.sv
// Reset-request controller: merges async hw and sw requests, stretches the pulse,
// keeps sticky causes. Optional RST_REQ_CTRL_RESTART_EN re-arms the stretch on new requests.
//
// state   | meaning
// IDLE    | no request active, rst_req_no high
// STRETCH | minimum-width pulse counting down
// HOLD    | minimum width done, a hardware source is still asserted
module rst_req_ctrl
    import rst_req_ctrl_pkg::*;
#(
    parameter int unsigned NumSrc         = 4,
    parameter int unsigned MinPulseCycles = 16,
    parameter int unsigned SyncStages     = 2,
    parameter int unsigned CntWidth       = (MinPulseCycles > 1) ? $clog2(MinPulseCycles) : 1
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              test_mode_i,
    input  logic [NumSrc-1:0] src_req_i,
    input  logic [NumSrc-1:0] src_mask_i,
    input  logic              sw_req_i,
    output logic              sw_ack_o,
    input  logic              cause_clr_i,
    output logic [NumSrc:0]   cause_o,
    output logic              busy_o,
    output logic              rst_req_no
);

    localparam int unsigned   SwCauseIdx = sw_cause_idx(NumSrc);
    localparam [CntWidth-1:0] MaxCnt     = CntWidth'(MinPulseCycles - 1);

    if (MinPulseCycles < 1) begin : g_bad_pulse
        $fatal(1, "rst_req_ctrl: MinPulseCycles must be >= 1");
    end
    if (SyncStages < 2) begin : g_bad_sync
        $fatal(1, "rst_req_ctrl: SyncStages must be >= 2");
    end

    rst_req_state_e    state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic              sw_pend_q, sw_pend_d;
    logic [NumSrc:0]   cause_q, cause_d;
    logic              busy_q, rst_req_q;
    logic [NumSrc-1:0] src_s, req_hw;
    logic              hw_any, sw_accept, stretch_exit;

    for (genvar i = 0; i < NumSrc; i++) begin : g_sync
        rst_req_ctrl_sync #(
            .STAGES    (SyncStages),
            .ResetValue(1'b0)
        ) u_sync (
            .clk_i   (clk_i),
            .rst_ni  (rst_n),
            .serial_i(src_req_i[i]),
            .serial_o(src_s[i])
        );
    end

    // Sources are ignored entirely while the DFT bypass is active.
    assign req_hw = test_mode_i ? '0 : (src_s & ~src_mask_i);
    assign hw_any = |req_hw;

`ifdef RST_REQ_CTRL_RESTART_EN
    logic [NumSrc-1:0] req_hw_q;
    logic              hw_rise, sw_new;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            req_hw_q <= '0;
        end else begin
            req_hw_q <= req_hw;
        end
    end

    assign hw_rise = |(req_hw & ~req_hw_q);
    assign sw_new  = sw_req_i & ~sw_pend_q;
`endif

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= STRETCH;
            cnt_q     <= MaxCnt;
            sw_pend_q <= 1'b0;
            cause_q   <= '0;
            busy_q    <= 1'b1;
            rst_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sw_pend_q <= sw_pend_d;
            cause_q   <= cause_d;
            busy_q    <= (state_d != IDLE);
            rst_req_q <= (state_d == IDLE);
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sw_pend_d    = sw_pend_q;
        sw_accept    = 1'b0;
        stretch_exit = 1'b0;
        if (test_mode_i) begin
            state_d   = IDLE;
            sw_pend_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hw_any || sw_req_i) begin
                        state_d   = STRETCH;
                        cnt_d     = MaxCnt;
                        sw_pend_d = sw_req_i;
                        sw_accept = sw_req_i;
                    end
                end
                STRETCH: begin
                    if (cnt_q == '0) begin
                        state_d      = hw_any ? HOLD : IDLE;
                        stretch_exit = 1'b1;
                        sw_pend_d    = 1'b0;
                    end else begin
                        cnt_d = cnt_q - CntWidth'(1);
                    end
                end
                HOLD: begin
                    if (!hw_any) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
`ifdef RST_REQ_CTRL_RESTART_EN
            // A fresh request re-arms the full minimum width; a pending ack is deferred.
            if ((state_q != IDLE) && (hw_rise || sw_new)) begin
                state_d      = STRETCH;
                cnt_d        = MaxCnt;
                stretch_exit = 1'b0;
                sw_pend_d    = sw_pend_q | sw_new;
                sw_accept    = sw_new;
            end
`endif
        end
    end

    // Sets win over the clear; everything freezes in test mode.
    always_comb begin
        cause_d = cause_q;
        if (!test_mode_i) begin
            if (cause_clr_i && (state_q == IDLE)) cause_d = '0;
            cause_d[NumSrc-1:0] = cause_d[NumSrc-1:0] | req_hw;
            if (sw_accept) cause_d[SwCauseIdx] = 1'b1;
        end
    end

    always_comb begin
        sw_ack_o   = stretch_exit & sw_pend_q;
        rst_req_no = test_mode_i ? rst_n : rst_req_q;
        busy_o     = busy_q;
        cause_o    = cause_q;
    end

endmodule

// File: tb/tb_rst_req_ctrl.sv
// Directed bench for rst_req_ctrl; expectations follow RST_REQ_CTRL_RESTART_EN when defined.
module tb_rst_req_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_n = 1'b0;
    logic       test_mode_i = 1'b0;
    logic [3:0] src_req_i = '0;
    logic [3:0] src_mask_i = '0;
    logic       sw_req_i = 1'b0;
    logic       sw_ack_o;
    logic       cause_clr_i = 1'b0;
    logic [4:0] cause_o;
    logic       busy_o;
    logic       rst_req_no;

    int vec_cnt = 0;
    int err_cnt = 0;

    rst_req_ctrl dut (
        .clk_i      (clk_i),
        .rst_n      (rst_n),
        .test_mode_i(test_mode_i),
        .src_req_i  (src_req_i),
        .src_mask_i (src_mask_i),
        .sw_req_i   (sw_req_i),
        .sw_ack_o   (sw_ack_o),
        .cause_clr_i(cause_clr_i),
        .cause_o    (cause_o),
        .busy_o     (busy_o),
        .rst_req_no (rst_req_no)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_fall(input int max, output int n);
        n = 0;
        while (rst_req_no && n < max) begin
            tick();
            n++;
        end
    endtask

    // Edges from the fall edge until rst_req_no rises; drops sw_req_i when acked.
    task automatic count_low(output int n, output int ack_at);
        n = 0;
        ack_at = -1;
        while (n < 200) begin
            if (sw_ack_o) begin
                ack_at = n;
                sw_req_i = 1'b0;
            end
            tick();
            n++;
            if (rst_req_no) break;
        end
    endtask

    task automatic clear_causes();
        cause_clr_i = 1'b1;
        tick();
        cause_clr_i = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        tick();
        tick();
        vec_cnt++; if (rst_req_no !== 1'b0) begin err_cnt++; $display("FAIL por_rst_req got=%b exp=0", rst_req_no); end
        vec_cnt++; if (busy_o !== 1'b1) begin err_cnt++; $display("FAIL por_busy got=%b exp=1", busy_o); end
        vec_cnt++; if (cause_o !== 5'b00000) begin err_cnt++; $display("FAIL por_cause got=%b exp=00000", cause_o); end
        vec_cnt++; if (sw_ack_o !== 1'b0) begin err_cnt++; $display("FAIL por_ack got=%b exp=0", sw_ack_o); end
        @(negedge clk_i);
        rst_n = 1'b1;
        n = 0;
        while (!rst_req_no && n < 100) begin
            tick();
            n++;
        end
        vec_cnt++; if (n !== 16) begin err_cnt++; $display("FAIL por_width got=%0d exp=16", n); end
        vec_cnt++; if (busy_o !== 1'b0) begin err_cnt++; $display("FAIL por_busy_end got=%b exp=0", busy_o); end
        vec_cnt++; if (cause_o !== 5'b00000) begin err_cnt++; $display("FAIL por_cause_end got=%b exp=00000", cause_o); end
    endtask

    task automatic test_sw();
        int n, ack_at;
        sw_req_i = 1'b1;
        tick();
        vec_cnt++; if (rst_req_no !== 1'b0) begin err_cnt++; $display("FAIL sw_fall got=%b exp=0", rst_req_no); end
        vec_cnt++; if (busy_o !== 1'b1) begin err_cnt++; $display("FAIL sw_busy got=%b exp=1", busy_o); end
        count_low(n, ack_at);
        vec_cnt++; if (n !== 16) begin err_cnt++; $display("FAIL sw_width got=%0d exp=16", n); end
        vec_cnt++; if (ack_at !== 15) begin err_cnt++; $display("FAIL sw_ack_pos got=%0d exp=15", ack_at); end
        vec_cnt++; if (cause_o !== 5'b10000) begin err_cnt++; $display("FAIL sw_cause got=%b exp=10000", cause_o); end
        vec_cnt++; if (sw_ack_o !== 1'b0) begin err_cnt++; $display("FAIL sw_ack_end got=%b exp=0", sw_ack_o); end
        clear_causes();
        vec_cnt++; if (cause_o !== 5'b00000) begin err_cnt++; $display("FAIL sw_cause_clr got=%b exp=00000", cause_o); end
        vec_cnt++; if (rst_req_no !== 1'b1) begin err_cnt++; $display("FAIL sw_no_retrigger got=%b exp=1", rst_req_no); end
    endtask

    task automatic test_hold();
        int n;
        logic rose;
        src_req_i[1] = 1'b1;
        wait_fall(10, n);
        vec_cnt++; if (n !== 3) begin err_cnt++; $display("FAIL hold_fall_edges got=%0d exp=3", n); end
        rose = 1'b0;
        for (int i = 0; i < 37; i++) begin
            cause_clr_i = (i == 20);
            tick();
            if (rst_req_no) rose = 1'b1;
        end
        cause_clr_i = 1'b0;
        vec_cnt++; if (rose !== 1'b0) begin err_cnt++; $display("FAIL hold_stays_low got=%b exp=0", rose); end
        vec_cnt++; if (cause_o !== 5'b00010) begin err_cnt++; $display("FAIL hold_cause got=%b exp=00010", cause_o); end
        src_req_i[1] = 1'b0;
        n = 0;
        while (!rst_req_no && n < 20) begin
            tick();
            n++;
        end
        vec_cnt++; if (n !== 3) begin err_cnt++; $display("FAIL hold_rise_edges got=%0d exp=3", n); end
        vec_cnt++; if (busy_o !== 1'b0) begin err_cnt++; $display("FAIL hold_busy_end got=%b exp=0", busy_o); end
        clear_causes();
    endtask

    task automatic test_mask_glitch();
        int n, ack_at;
        logic fell;
        src_mask_i = 4'b0001;
        src_req_i[0] = 1'b1;
        fell = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!rst_req_no) fell = 1'b1;
        end
        vec_cnt++; if (fell !== 1'b0) begin err_cnt++; $display("FAIL mask_no_reset got=%b exp=0", fell); end
        vec_cnt++; if (cause_o !== 5'b00000) begin err_cnt++; $display("FAIL mask_cause got=%b exp=00000", cause_o); end
        src_req_i[0] = 1'b0;
        repeat (4) tick();
        src_mask_i = 4'b0000;
        src_req_i[2] = 1'b1;
        tick();
        src_req_i[2] = 1'b0;
        wait_fall(10, n);
        vec_cnt++; if (n !== 2) begin err_cnt++; $display("FAIL glitch_fall_edges got=%0d exp=2", n); end
        count_low(n, ack_at);
        vec_cnt++; if (n !== 16) begin err_cnt++; $display("FAIL glitch_width got=%0d exp=16", n); end
        vec_cnt++; if (ack_at !== -1) begin err_cnt++; $display("FAIL glitch_no_ack got=%0d exp=-1", ack_at); end
        vec_cnt++; if (cause_o !== 5'b00100) begin err_cnt++; $display("FAIL glitch_cause got=%b exp=00100", cause_o); end
        clear_causes();
    endtask

    task automatic test_simultaneous();
        int n, ack_at;
        src_req_i[3] = 1'b1;
        tick();
        src_req_i[3] = 1'b0;
        tick();
        sw_req_i = 1'b1;
        tick();
        vec_cnt++; if (rst_req_no !== 1'b0) begin err_cnt++; $display("FAIL simul_fall got=%b exp=0", rst_req_no); end
        count_low(n, ack_at);
        vec_cnt++; if (n !== 16) begin err_cnt++; $display("FAIL simul_width got=%0d exp=16", n); end
        vec_cnt++; if (ack_at !== 15) begin err_cnt++; $display("FAIL simul_ack_pos got=%0d exp=15", ack_at); end
        vec_cnt++; if (cause_o !== 5'b11000) begin err_cnt++; $display("FAIL simul_cause got=%b exp=11000", cause_o); end
        clear_causes();
    endtask

    task automatic test_restart();
        int n, exp_w;
`ifdef RST_REQ_CTRL_RESTART_EN
        exp_w = 26;
`else
        exp_w = 16;
`endif
        src_req_i[2] = 1'b1;
        tick();
        src_req_i[2] = 1'b0;
        wait_fall(10, n);
        repeat (7) tick();
        src_req_i[3] = 1'b1;
        tick();
        src_req_i[3] = 1'b0;
        n = 8;
        while (!rst_req_no && n < 200) begin
            tick();
            n++;
        end
        vec_cnt++; if (n !== exp_w) begin err_cnt++; $display("FAIL restart_width got=%0d exp=%0d", n, exp_w); end
        vec_cnt++; if (cause_o !== 5'b01100) begin err_cnt++; $display("FAIL restart_cause got=%b exp=01100", cause_o); end
        clear_causes();
    endtask

    task automatic test_midreset();
        int n;
        src_req_i[0] = 1'b1;
        tick();
        src_req_i[0] = 1'b0;
        wait_fall(10, n);
        repeat (5) tick();
        vec_cnt++; if (cause_o !== 5'b00001) begin err_cnt++; $display("FAIL midrst_cause_pre got=%b exp=00001", cause_o); end
        @(negedge clk_i);
        rst_n = 1'b0;
        #1;
        vec_cnt++; if (cause_o !== 5'b00000) begin err_cnt++; $display("FAIL midrst_cause got=%b exp=00000", cause_o); end
        vec_cnt++; if (rst_req_no !== 1'b0) begin err_cnt++; $display("FAIL midrst_rst_req got=%b exp=0", rst_req_no); end
        vec_cnt++; if (busy_o !== 1'b1) begin err_cnt++; $display("FAIL midrst_busy got=%b exp=1", busy_o); end
        tick();
        @(negedge clk_i);
        rst_n = 1'b1;
        n = 0;
        while (!rst_req_no && n < 100) begin
            tick();
            n++;
        end
        vec_cnt++; if (n !== 16) begin err_cnt++; $display("FAIL midrst_width got=%0d exp=16", n); end
    endtask

    task automatic test_test_mode();
        int n, ack_at;
        logic bad_rst, bad_ack;
        src_req_i[1] = 1'b1;
        tick();
        src_req_i[1] = 1'b0;
        wait_fall(10, n);
        count_low(n, ack_at);
        test_mode_i = 1'b1;
        #1;
        vec_cnt++; if (rst_req_no !== 1'b1) begin err_cnt++; $display("FAIL tm_rst_req got=%b exp=1", rst_req_no); end
        src_req_i = 4'b1111;
        sw_req_i = 1'b1;
        cause_clr_i = 1'b1;
        bad_rst = 1'b0;
        bad_ack = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (!rst_req_no) bad_rst = 1'b1;
            if (sw_ack_o) bad_ack = 1'b1;
        end
        cause_clr_i = 1'b0;
        vec_cnt++; if (bad_rst !== 1'b0) begin err_cnt++; $display("FAIL tm_ignores_src got=%b exp=0", bad_rst); end
        vec_cnt++; if (bad_ack !== 1'b0) begin err_cnt++; $display("FAIL tm_no_ack got=%b exp=0", bad_ack); end
        vec_cnt++; if (cause_o !== 5'b00010) begin err_cnt++; $display("FAIL tm_cause_frozen got=%b exp=00010", cause_o); end
        vec_cnt++; if (busy_o !== 1'b0) begin err_cnt++; $display("FAIL tm_busy got=%b exp=0", busy_o); end
        @(negedge clk_i);
        rst_n = 1'b0;
        #1;
        vec_cnt++; if (rst_req_no !== 1'b0) begin err_cnt++; $display("FAIL tm_track_low got=%b exp=0", rst_req_no); end
        #2;
        rst_n = 1'b1;
        #1;
        vec_cnt++; if (rst_req_no !== 1'b1) begin err_cnt++; $display("FAIL tm_track_high got=%b exp=1", rst_req_no); end
        src_req_i = 4'b0000;
        sw_req_i = 1'b0;
        repeat (4) tick();
        test_mode_i = 1'b0;
        tick();
        tick();
        vec_cnt++; if (rst_req_no !== 1'b1) begin err_cnt++; $display("FAIL tm_exit_quiet got=%b exp=1", rst_req_no); end
    endtask

    initial begin
        test_reset();
        test_sw();
        test_hold();
        test_mask_glitch();
        test_simultaneous();
        test_restart();
        test_midreset();
        test_test_mode();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
